// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
//
// Single-master I2C controller. One host request produces a complete bus
// transaction: START, 7-bit address + R/W, 0..7 data bytes with ACK/NAK
// handling in both directions, then STOP. SCL and SDA are open-drain: the
// block only ever drives 0 or releases the line (z).
//
// Every bus bit is built from four quarters of CLKDIV clocks each:
//   Q0 SCL low, SDA updated | Q1 SCL low | Q2 SCL released | Q3 SCL high,
//   SDA sampled (through a 2-FF synchroniser) on entry to Q3.
// An accepted request first spends one quarter in a lead-in before START.
//
// Optional feature macro: I2C_MASTER_STRETCH_EN
//   defined     - while SCL is released in Q2/Q3 and the synchronised SCL
//                 still reads 0, the quarter divider holds (slave clock
//                 stretching, no timeout).
//   not defined - SCL is never read back; timing is free-running.
//
// Parameters
//   CLKDIV  clocks per SCL quarter-period (>= 4); f(SCL) = f(CLCK)/(4*CLKDIV)
//
// Ports
//   CLCK    in   system clock, rising edge
//   RSTN    in   asynchronous active-low reset
//   START   in   request strobe, accepted only while BUSY=0
//   RW      in   0 = write, 1 = read (sampled with START)
//   ADDR    in   7-bit target address (sampled with START)
//   NBYTES  in   data bytes in transaction, 0 = address-only probe
//   WDATA   in   write byte; first with START, later ones after WREQ
//   WREQ    out  one-cycle pulse: present the next write byte
//   RDATA   out  last received byte
//   RVALID  out  one-cycle pulse when RDATA updates
//   BUSY    out  high from request accept until STOP completes
//   DONE    out  one-cycle pulse at the end of STOP
//   NACK    out  sticky: slave NAKed address or a write byte
//   SCL     io   open-drain clock
//   SDA     io   open-drain data
// ---------------------------------------------------------------------------
module i2c_master #(
  parameter int CLKDIV = 25
) (
  input  logic       CLCK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       RW,
  input  logic [6:0] ADDR,
  input  logic [2:0] NBYTES,
  input  logic [7:0] WDATA,
  output logic       WREQ,
  output logic [7:0] RDATA,
  output logic       RVALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       NACK,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLKDIV - 1);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_STRT = 4'd1;
  localparam logic [3:0] ST_ADDR = 4'd2;
  localparam logic [3:0] ST_AACK = 4'd3;
  localparam logic [3:0] ST_WDAT = 4'd4;
  localparam logic [3:0] ST_WACK = 4'd5;
  localparam logic [3:0] ST_RDAT = 4'd6;
  localparam logic [3:0] ST_RACK = 4'd7;
  localparam logic [3:0] ST_STOP = 4'd8;

  logic [3:0]    state;
  logic [1:0]    q;          // current quarter within the bus bit
  logic [CW-1:0] cnt;        // quarter divider
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_cnt;   // data bytes not yet started
  logic          rw_r;
  logic          ack_smp;    // SDA value captured on entry to Q3
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    wbuf;
  logic          sda_s1, sda_s2;
  logic          scl_lo, sda_lo;
  logic          scl_lo_d, sda_lo_d;
  logic          tick;
  logic          stall;

  assign SCL = scl_lo ? 1'b0 : 1'bz;
  assign SDA = sda_lo ? 1'b0 : 1'bz;

`ifdef I2C_MASTER_STRETCH_EN
  logic scl_s1, scl_s2;

  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
    end
  end

  // The check is made only at the quarter boundary, so the few cycles the
  // synchroniser needs to see our own release never count as stretching.
  // scl_lo excludes quarters where we hold SCL low ourselves (STRT Q3).
  assign stall = q[1] && !scl_lo && !scl_s2;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
    end
  end

  assign tick = BUSY && (cnt == DIV_MAX) && !stall;

  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (!BUSY) begin
      cnt <= '0;
    end else if (cnt == DIV_MAX) begin
      if (!stall) cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Control FSM. Bit-level transitions happen on the tick that ends Q3;
  // actions tied to "entry to Q3" happen on the tick that ends Q2.
  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      q        <= 2'd3;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
      rw_r     <= 1'b0;
      ack_smp  <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NACK     <= 1'b0;
      WREQ     <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= 8'h00;
    end else begin
      WREQ   <= 1'b0;
      RVALID <= 1'b0;
      DONE   <= 1'b0;
      if (!BUSY) begin
        // q parked at 3 so the first tick after accept is a bit boundary
        // (the lead-in quarter) that moves IDLE -> STRT.
        state <= ST_IDLE;
        q     <= 2'd3;
        if (START) begin
          BUSY     <= 1'b1;
          NACK     <= 1'b0;
          rw_r     <= RW;
          byte_cnt <= NBYTES;
        end
      end else if (DONE) begin
        BUSY  <= 1'b0;
        state <= ST_IDLE;
        q     <= 2'd3;
      end else if (tick) begin
        q <= q + 2'd1;
        if (q == 2'd2) begin
          ack_smp <= sda_s2;
          if (state == ST_STOP) DONE <= 1'b1;
        end
        if (q == 2'd3) begin
          case (state)
            ST_IDLE: state <= ST_STRT;
            ST_STRT: begin
              state   <= ST_ADDR;
              bit_cnt <= 3'd7;
            end
            ST_ADDR: begin
              if (bit_cnt == 3'd0) state <= ST_AACK;
              else bit_cnt <= bit_cnt - 3'd1;
            end
            ST_AACK: begin
              if (ack_smp) begin
                NACK  <= 1'b1;
                state <= ST_STOP;
              end else if (byte_cnt == 3'd0) begin
                state <= ST_STOP;
              end else begin
                state   <= rw_r ? ST_RDAT : ST_WDAT;
                bit_cnt <= 3'd7;
              end
            end
            ST_WDAT: begin
              if (bit_cnt == 3'd0) begin
                state    <= ST_WACK;
                byte_cnt <= byte_cnt - 3'd1;
                // ask for the next byte only if one will follow this one
                if (byte_cnt != 3'd1) WREQ <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
            ST_WACK: begin
              if (ack_smp) begin
                NACK  <= 1'b1;
                state <= ST_STOP;
              end else if (byte_cnt == 3'd0) begin
                state <= ST_STOP;
              end else begin
                state   <= ST_WDAT;
                bit_cnt <= 3'd7;
              end
            end
            ST_RDAT: begin
              if (bit_cnt == 3'd0) begin
                state    <= ST_RACK;
                byte_cnt <= byte_cnt - 3'd1;
                RDATA    <= rx_sh;
                RVALID   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
            ST_RACK: begin
              if (byte_cnt == 3'd0) state <= ST_STOP;
              else begin
                state   <= ST_RDAT;
                bit_cnt <= 3'd7;
              end
            end
            ST_STOP: state <= ST_STOP;  // left via DONE
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Datapath shift registers; always loaded before use, so no reset.
  always_ff @(posedge CLCK) begin
    if (!BUSY && START) begin
      tx_sh <= {ADDR, RW};
      wbuf  <= WDATA;
    end else if (tick) begin
      if (q == 2'd2) begin
        if (state == ST_WACK && byte_cnt != 3'd0) wbuf <= WDATA;
        if (state == ST_RDAT) rx_sh <= {rx_sh[6:0], sda_s2};
      end
      if (q == 2'd3) begin
        if ((state == ST_ADDR || state == ST_WDAT) && bit_cnt != 3'd0)
          tx_sh <= {tx_sh[6:0], 1'b0};
        else if ((state == ST_AACK && !rw_r) || state == ST_WACK)
          tx_sh <= wbuf;
      end
    end
  end

  // Line drive (1 = pull low) as a function of state and quarter.
  always_comb begin
    scl_lo_d = 1'b0;
    sda_lo_d = 1'b0;
    case (state)
      ST_STRT: begin
        sda_lo_d = q[1];
        scl_lo_d = (q == 2'd3);
      end
      ST_ADDR, ST_WDAT: begin
        scl_lo_d = !q[1];
        sda_lo_d = !tx_sh[7];
      end
      ST_AACK, ST_WACK, ST_RDAT: scl_lo_d = !q[1];
      ST_RACK: begin
        scl_lo_d = !q[1];
        sda_lo_d = (byte_cnt != 3'd0);  // ACK unless this was the last byte
      end
      ST_STOP: begin
        scl_lo_d = (q == 2'd0);
        sda_lo_d = !q[1];
      end
      default: ;
    endcase
    if (!BUSY) begin
      scl_lo_d = 1'b0;
      sda_lo_d = 1'b0;
    end
  end

  // Registered line drivers; asynchronous reset releases both lines at once.
  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      scl_lo <= 1'b0;
      sda_lo <= 1'b0;
    end else begin
      scl_lo <= scl_lo_d;
      sda_lo <= sda_lo_d;
    end
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-master I2C bus controller that generates START, 7-bit address, R/W bit, up to 7 data bytes and STOP on open-drain SCL/SDA, directly driving the I2C slave stage on the same bus. It is the upstream transaction source: host logic issues one request, and the block sequences the whole bus transaction, handling write data fetch, read data return and ACK/NAK checking.

## Interface
- CLKDIV, 25, CLCK cycles per SCL quarter-period (minimum 4); SCL frequency = f(CLCK)/(4*CLKDIV)
- CLCK  input  1  system clock, all logic on rising edge
- RSTN  input  1  asynchronous active-low reset
- START  input  1  request strobe, accepted only when BUSY=0
- RW  input  1  0 = write, 1 = read; sampled with START
- ADDR  input  7  target address; sampled with START
- NBYTES  input  3  data bytes in transaction (0–7); 0 = address-only probe
- WDATA  input  8  write byte; first byte sampled with START, later bytes on WREQ handshake
- WREQ  output  1  one-cycle pulse: supply next WDATA
- RDATA  output  8  last received byte, held until next read byte
- RVALID  output  1  one-cycle pulse when RDATA updates
- BUSY  output  1  high from START accept until STOP complete
- DONE  output  1  one-cycle pulse at end of STOP
- NACK  output  1  sticky: slave NAKed address or write byte; cleared on next START accept
- SCL  inout  1  open-drain: drives 0 or z
- SDA  inout  1  open-drain: drives 0 or z

## Operation
- Reset values: WREQ=0, RVALID=0, BUSY=0, DONE=0, NACK=0, RDATA=8'h00, SCL=z, SDA=z, state IDLE.
- Quarter tick: divider counter, width $clog2(CLKDIV), pulses every CLKDIV cycles while BUSY; cleared in IDLE.
- Every bus bit = 4 quarters Q0–Q3: Q0 SCL low, SDA updated; Q1 SCL low; Q2 SCL released; Q3 SCL high, SDA sampled on entry via 2-FF synchroniser.
- States: IDLE → STRT → ADDR (8 bits: ADDR[6:0] MSB first, then RW) → AACK → WDAT/RDAT ↔ WACK/RACK → STOP → IDLE.
- STRT: Q0–Q1 SDA z, SCL z; Q2 SDA 0; Q3 SCL 0.
- AACK: SDA released; sampled 1 → NACK=1, go STOP. Sampled 0 with NBYTES=0 → STOP.
- WDAT: shift 8 bits MSB first. WACK: release SDA; WREQ pulses at Q0 if bytes remain; WDATA latched at Q3. Sampled 1 → NACK=1, STOP.
- RDAT: release SDA, shift sampled bits MSB first. RACK: RDATA updated and RVALID pulses at Q0; master drives 0 (ACK) if bytes remain, z (NAK) on final byte.
- STOP: Q0 SDA 0, SCL 0; Q1 SCL z; Q2 SDA z; Q3 DONE pulse, BUSY drops next cycle.
- Counters: 3-bit bit counter, 3-bit byte counter decremented per data byte; transaction ends at zero, no wrap.
- START while BUSY=1 ignored, no latch. START and DONE same cycle: START ignored.
- RSTN low mid-transaction: SCL/SDA released immediately (asynchronous), all state to reset values; no STOP issued.

## Timing
- START accept → SDA falls: 3*CLKDIV cycles (+1 registration).
- Full transaction length: (1 + 9*(1+NBYTES) + 1) bus bits of 4*CLKDIV cycles each.
- WREQ → WDATA needed: by Q3 of same ACK bit, ≥3*CLKDIV−1 cycles.
- RVALID: at Q0 of RACK, 1 cycle after final bit sample plus one quarter.
- SDA never changes while SCL high except in STRT/STOP.

## Configuration
- I2C_MASTER_STRETCH_EN defined: at Q2/Q3, if synchronised SCL reads 0 while released, divider holds until SCL reads 1 (slave clock stretching honoured; no timeout).
- Not defined: SCL input ignored; quarter timing free-running from divider only.

## Test plan
- Write: ADDR=7'h72, RW=0, NBYTES=1, WDATA=8'hA5; slave ACKs → bus bits E4, A5, STOP; DONE once, NACK=0.
- Address NAK: ADDR=7'h10, no ACK → SDA high at AACK, NACK=1, STOP follows, no WREQ.
- Read: ADDR=7'h72, RW=1, NBYTES=3, slave returns 3C,3C,3C → three RVALID with RDATA=8'h3C; master ACK, ACK, NAK.
- Multi-write: NBYTES=3, bench returns 11,22,33 on WREQ → exactly 2 WREQ pulses, bus data 11 22 33.
- Probe: NBYTES=0 → START, address, ACK, STOP; total 11 bus bits.
- RSTN asserted mid-data-byte → SCL=z, SDA=z same cycle, BUSY=0; new START after release runs cleanly.
